// File: rtl/score_keeper_if.sv
// Bus between score_keeper and its game/renderer neighbours.
// SCORE_BCD_EN adds the BCD digit outputs disp_tens/disp_ones.
interface score_keeper_if #(
  parameter int unsigned SCORE_W = 6
);
  logic               start;
  logic               hit;
  logic               miss;
  logic               frame_sync;
  logic [1:0]         game_state;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] high_score;
  logic [2:0]         misses;
  logic               new_record;
  logic [SCORE_W-1:0] display_score;
`ifdef SCORE_BCD_EN
  logic [3:0]         disp_tens;
  logic [3:0]         disp_ones;

  modport master (
    output start, hit, miss, frame_sync,
    input  game_state, score, high_score, misses, new_record, display_score,
    input  disp_tens, disp_ones
  );
  modport slave (
    input  start, hit, miss, frame_sync,
    output game_state, score, high_score, misses, new_record, display_score,
    output disp_tens, disp_ones
  );
`else
  modport master (
    output start, hit, miss, frame_sync,
    input  game_state, score, high_score, misses, new_record, display_score
  );
  modport slave (
    input  start, hit, miss, frame_sync,
    output game_state, score, high_score, misses, new_record, display_score
  );
`endif
endinterface

// File: rtl/score_keeper.sv
// Piano-tiles score FSM: hit/miss counting, life limit, session high score, frame-stable display.
// Optional SCORE_BCD_EN: incremental BCD digits of score/high score latched for the renderer.
module score_keeper #(
  parameter int unsigned SCORE_W    = 6,
  parameter int unsigned SCORE_MAX  = 63,
  parameter int unsigned MISS_LIMIT = 3
) (
  input  logic          Clk,
  input  logic          Reset_n,
  score_keeper_if.slave bus
);

  localparam logic [SCORE_W-1:0] MAX_C   = SCORE_W'(SCORE_MAX);
  localparam logic [2:0]         LIMIT_C = 3'(MISS_LIMIT);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    PLAYING   = 2'b01,
    GAME_OVER = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic [2:0]         misses_q, misses_d;
  logic               rec_q, rec_d;
  logic [SCORE_W-1:0] disp_q, disp_d;
  logic [SCORE_W:0]   sum_c;
`ifdef SCORE_BCD_EN
  logic [3:0] tens_q, tens_d, ones_q, ones_d;
  logic [3:0] htens_q, htens_d, hones_q, hones_d;
  logic [3:0] dtens_q, dtens_d, dones_q, dones_d;
`endif

  // Next-state: game FSM, score/miss counters, high-score capture, display latch
  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    high_d   = high_q;
    misses_d = misses_q;
    rec_d    = rec_q;
    disp_d   = disp_q;
    sum_c    = {1'b0, score_q} + (SCORE_W+1)'(1);
`ifdef SCORE_BCD_EN
    tens_d  = tens_q;
    ones_d  = ones_q;
    htens_d = htens_q;
    hones_d = hones_q;
    dtens_d = dtens_q;
    dones_d = dones_q;
`endif

    unique case (state_q)
      IDLE, GAME_OVER: begin
        if (bus.start) begin
          state_d  = PLAYING;
          score_d  = '0;
          misses_d = '0;
          rec_d    = 1'b0;
`ifdef SCORE_BCD_EN
          tens_d = '0;
          ones_d = '0;
`endif
        end
      end
      PLAYING: begin
        if (bus.hit) begin
          score_d = (sum_c > {1'b0, MAX_C}) ? MAX_C : sum_c[SCORE_W-1:0];
`ifdef SCORE_BCD_EN
          // Digits advance only while the binary score does, so they saturate together
          if (score_q < MAX_C) begin
            if (ones_q == 4'd9) begin
              ones_d = '0;
              tens_d = tens_q + 4'd1;
            end else begin
              ones_d = ones_q + 4'd1;
            end
          end
`endif
        end
        if (bus.miss) begin
          misses_d = misses_q + 3'd1;
          if (misses_q + 3'd1 == LIMIT_C) begin
            state_d = GAME_OVER;
            if (score_d > high_q) begin
              high_d = score_d;
              rec_d  = 1'b1;
`ifdef SCORE_BCD_EN
              htens_d = tens_d;
              hones_d = ones_d;
`endif
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Latch pre-update values so a coinciding score change shows on the next frame
    if (bus.frame_sync) begin
      disp_d = (state_q == GAME_OVER) ? high_q : score_q;
`ifdef SCORE_BCD_EN
      dtens_d = (state_q == GAME_OVER) ? htens_q : tens_q;
      dones_d = (state_q == GAME_OVER) ? hones_q : ones_q;
`endif
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      score_q  <= '0;
      high_q   <= '0;
      misses_q <= '0;
      rec_q    <= 1'b0;
      disp_q   <= '0;
`ifdef SCORE_BCD_EN
      tens_q  <= '0;
      ones_q  <= '0;
      htens_q <= '0;
      hones_q <= '0;
      dtens_q <= '0;
      dones_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      high_q   <= high_d;
      misses_q <= misses_d;
      rec_q    <= rec_d;
      disp_q   <= disp_d;
`ifdef SCORE_BCD_EN
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      htens_q <= htens_d;
      hones_q <= hones_d;
      dtens_q <= dtens_d;
      dones_q <= dones_d;
`endif
    end
  end

  assign bus.game_state    = state_q;
  assign bus.score         = score_q;
  assign bus.high_score    = high_q;
  assign bus.misses        = misses_q;
  assign bus.new_record    = rec_q;
  assign bus.display_score = disp_q;
`ifdef SCORE_BCD_EN
  assign bus.disp_tens     = dtens_q;
  assign bus.disp_ones     = dones_q;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: expected values queued as stimulus is driven.
// Digit checks are included when SCORE_BCD_EN is defined.
module tb_score_keeper;

  localparam int unsigned SCORE_W = 6;

  typedef enum int {F_STATE, F_SCORE, F_HIGH, F_MISSES, F_REC, F_DISP, F_TENS, F_ONES} fld_e;
  typedef struct {
    fld_e        f;
    logic [31:0] v;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  score_keeper_if #(.SCORE_W(SCORE_W)) bus ();

  score_keeper #(.SCORE_W(SCORE_W), .SCORE_MAX(63), .MISS_LIMIT(3)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] obs(fld_e f);
    case (f)
      F_STATE:  return 32'(bus.game_state);
      F_SCORE:  return 32'(bus.score);
      F_HIGH:   return 32'(bus.high_score);
      F_MISSES: return 32'(bus.misses);
      F_REC:    return 32'(bus.new_record);
      F_DISP:   return 32'(bus.display_score);
`ifdef SCORE_BCD_EN
      F_TENS:   return 32'(bus.disp_tens);
      F_ONES:   return 32'(bus.disp_ones);
`endif
      default:  return '1;
    endcase
  endfunction

  task automatic push(fld_e f, int v);
    exp_t e;
    e.f = f;
    e.v = 32'(v);
    sb.push_back(e);
  endtask

  // One input cycle; returns 1 time unit after the sampling edge
  task automatic cyc(logic s, logic h, logic m, logic fs);
    @(negedge Clk);
    bus.start = s; bus.hit = h; bus.miss = m; bus.frame_sync = fs;
    @(posedge Clk);
    #1;
    bus.start = 0; bus.hit = 0; bus.miss = 0; bus.frame_sync = 0;
  endtask

  task automatic hits(int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0);
  endtask

  task automatic misses3();
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
  endtask

  task automatic test_reset();
    exp_t e;
    push(F_STATE, 0); push(F_SCORE, 0); push(F_HIGH, 0);
    push(F_MISSES, 0); push(F_REC, 0); push(F_DISP, 0);
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (obs(e.f) !== e.v) begin errors++; $display("FAIL reset_init %s: got %0d expected %0d", e.f.name(), obs(e.f), e.v); end
    end
    @(negedge Clk); Reset_n = 1'b1;
    cyc(1, 0, 0, 0); hits(20); misses3();
    cyc(1, 0, 0, 0); hits(12); cyc(0, 0, 0, 1);
    push(F_STATE, 1); push(F_SCORE, 12); push(F_HIGH, 20); push(F_DISP, 12);
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (obs(e.f) !== e.v) begin errors++; $display("FAIL reset_pre %s: got %0d expected %0d", e.f.name(), obs(e.f), e.v); end
    end
    #2 Reset_n = 1'b0;
    push(F_STATE, 0); push(F_SCORE, 0); push(F_HIGH, 0);
    push(F_MISSES, 0); push(F_REC, 0); push(F_DISP, 0);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (obs(e.f) !== e.v) begin errors++; $display("FAIL reset_async %s: got %0d expected %0d", e.f.name(), obs(e.f), e.v); end
    end
    @(negedge Clk); Reset_n = 1'b1;
  endtask

  task automatic test_basic_game();
    exp_t e;
    cyc(1, 0, 0, 0); hits(5);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    push(F_STATE, 1); push(F_MISSES, 2);
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (obs(e.f) !== e.v) begin errors++; $display("FAIL basic_mid %s: got %0d expected %0d", e.f.name(), obs(e.f), e.v); end
    end
    cyc(0, 0, 1, 0); cyc(0, 0, 0, 1);
    push(F_STATE, 2); push(F_SCORE, 5); push(F_HIGH, 5); push(F_REC, 1); push(F_DISP, 5);
`ifdef SCORE_BCD_EN
    push(F_TENS, 0); push(F_ONES, 5);
`endif
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (obs(e.f) !== e.v) begin errors++; $display("FAIL basic_end %s: got %0d expected %0d", e.f.name(), obs(e.f), e.v); end
    end
  endtask

  task automatic test_same_cycle();
    exp_t e;
    cyc(1, 0, 0, 0); hits(7);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0); cyc(0, 1, 1, 0);
    push(F_STATE, 2); push(F_SCORE, 8); push(F_HIGH, 8); push(F_REC, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (obs(e.f) !== e.v) begin errors++; $display("FAIL hit_miss_same %s: got %0d expected %0d", e.f.name(), obs(e.f), e.v); end
    end
    cyc(1, 1, 0, 0);
    push(F_STATE, 1); push(F_SCORE, 0); push(F_MISSES, 0); push(F_REC, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (obs(e.f) !== e.v) begin errors++; $display("FAIL start_hit_same %s: got %0d expected %0d", e.f.name(), obs(e.f), e.v); end
    end
    misses3();
    push(F_STATE, 2); push(F_HIGH, 8); push(F_REC, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (obs(e.f) !== e.v) begin errors++; $display("FAIL zero_game %s: got %0d expected %0d", e.f.name(), obs(e.f), e.v); end
    end
  endtask

  task automatic test_tie_lower();
    exp_t e;
    cyc(1, 0, 0, 0); hits(8); misses3();
    push(F_STATE, 2); push(F_SCORE, 8); push(F_HIGH, 8); push(F_REC, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (obs(e.f) !== e.v) begin errors++; $display("FAIL tie %s: got %0d expected %0d", e.f.name(), obs(e.f), e.v); end
    end
    cyc(1, 0, 0, 0); hits(4); misses3(); cyc(0, 0, 0, 1);
    push(F_SCORE, 4); push(F_HIGH, 8); push(F_REC, 0); push(F_DISP, 8);
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (obs(e.f) !== e.v) begin errors++; $display("FAIL lower %s: got %0d expected %0d", e.f.name(), obs(e.f), e.v); end
    end
  endtask

  task automatic test_frame_hold();
    exp_t e;
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 1); hits(3);
    push(F_SCORE, 3); push(F_DISP, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (obs(e.f) !== e.v) begin errors++; $display("FAIL frame_hold %s: got %0d expected %0d", e.f.name(), obs(e.f), e.v); end
    end
    cyc(0, 1, 0, 1);
    push(F_SCORE, 4); push(F_DISP, 3);
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (obs(e.f) !== e.v) begin errors++; $display("FAIL frame_same_edge %s: got %0d expected %0d", e.f.name(), obs(e.f), e.v); end
    end
    cyc(0, 0, 0, 1);
    push(F_DISP, 4);
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (obs(e.f) !== e.v) begin errors++; $display("FAIL frame_next %s: got %0d expected %0d", e.f.name(), obs(e.f), e.v); end
    end
    misses3();
  endtask

  task automatic test_saturation();
    exp_t e;
    cyc(1, 0, 0, 0); hits(70); cyc(0, 0, 0, 1);
    push(F_STATE, 1); push(F_SCORE, 63); push(F_DISP, 63);
`ifdef SCORE_BCD_EN
    push(F_TENS, 6); push(F_ONES, 3);
`endif
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (obs(e.f) !== e.v) begin errors++; $display("FAIL saturate %s: got %0d expected %0d", e.f.name(), obs(e.f), e.v); end
    end
    misses3(); cyc(0, 0, 0, 1);
    push(F_STATE, 2); push(F_HIGH, 63); push(F_REC, 1); push(F_DISP, 63);
`ifdef SCORE_BCD_EN
    push(F_TENS, 6); push(F_ONES, 3);
`endif
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (obs(e.f) !== e.v) begin errors++; $display("FAIL saturate_high %s: got %0d expected %0d", e.f.name(), obs(e.f), e.v); end
    end
  endtask

  initial begin
    bus.start = 0; bus.hit = 0; bus.miss = 0; bus.frame_sync = 0;
    test_reset();
    test_basic_game();
    test_same_cycle();
    test_tie_lower();
    test_frame_hold();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
